// File: rtl/multicycle_controller.sv
// Control FSM for a multi-cycle RV32I core: decodes IR fields and sequences the
// shared memory/ALU datapath through FETCH, DECODE and per-class execute states.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       instr_done,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALR2    = 4'd12,
        S_LUI      = 4'd13
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b100;

    state_t state_q, state_d;
    logic   legal;

    function automatic logic alu_f3_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b100) ||
               (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // sub is only selected for R-type; immediates pass use_f7=0 so addi stays add.
    function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic f7_5,
                                           input logic use_f7);
        logic [2:0] ctl;
        ctl = ALU_ADD;
        case (f3)
            3'b000:  ctl = (use_f7 && f7_5) ? ALU_SUB : ALU_ADD;
            3'b010:  ctl = ALU_SLT;
            3'b100:  ctl = ALU_XOR;
            3'b110:  ctl = ALU_OR;
            3'b111:  ctl = ALU_AND;
            default: ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_LW, OP_SW: legal = (func3 == 3'b010);
            OP_R, OP_I:   legal = alu_f3_ok(func3);
            OP_BR:        legal = (func3 == 3'b000) || (func3 == 3'b001) ||
                                  (func3 == 3'b100) || (func3 == 3'b101);
            OP_JALR:      legal = (func3 == 3'b000);
            OP_JAL, OP_LUI: legal = 1'b1;
            default:      legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (legal) begin
                    case (opcode)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_R:         state_d = S_EXECR;
                        OP_I:         state_d = S_EXECI;
                        OP_BR:        state_d = S_BRANCH;
                        OP_JAL:       state_d = S_JAL;
                        OP_JALR:      state_d = S_JALR;
                        OP_LUI:       state_d = S_LUI;
                        default:      state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: state_d = S_MEMWB;
            S_EXECR:   state_d = S_ALUWB;
            S_EXECI:   state_d = S_ALUWB;
            S_JAL:     state_d = S_ALUWB;
            S_JALR:    state_d = S_JALR2;
            S_JALR2:   state_d = S_ALUWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Outputs decode straight from the state register; rst masks them in the same cycle.
    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        ImmSrc     = IMM_I;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    IRWrite   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    PCWrite   = 1'b1;
                end
                S_DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    ImmSrc  = IMM_B;
                    if (!legal) begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    ImmSrc  = (opcode == OP_SW) ? IMM_S : IMM_I;
                end
                S_MEMREAD: AdrSrc = 1'b1;
                S_MEMWB: begin
                    ResultSrc  = 2'b01;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWRITE: begin
                    AdrSrc     = 1'b1;
                    MemWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_EXECR: begin
                    ALUSrcA    = 2'b10;
                    ALUControl = alu_dec(func3, func7[5], 1'b1);
                end
                S_EXECI: begin
                    ALUSrcA    = 2'b10;
                    ALUSrcB    = 2'b01;
                    ALUControl = alu_dec(func3, func7[5], 1'b0);
                end
                S_ALUWB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA    = 2'b10;
                    instr_done = 1'b1;
                    case (func3)
                        3'b000: begin ALUControl = ALU_SUB; PCWrite = zero;  end
                        3'b001: begin ALUControl = ALU_SUB; PCWrite = !zero; end
                        3'b100: begin ALUControl = ALU_SLT; PCWrite = !zero; end
                        3'b101: begin ALUControl = ALU_SLT; PCWrite = zero;  end
                        default: PCWrite = 1'b0;
                    endcase
                end
                S_JAL, S_JALR2: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    PCWrite = 1'b1;
                end
                S_JALR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                end
                S_LUI: begin
                    ImmSrc     = IMM_U;
                    ResultSrc  = 2'b11;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
